// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the parametrised register file.
// Build option: REGFILE_BYPASS_EN (see banco_registradores_param).
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef logic [0:0] state_t;

    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode reservations,
// cleared by write-back. Register 0 never has a pending producer.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     set_i,
    input  logic [ADDR_W-1:0]        set_idx_i,
    input  logic                     clr_i,
    input  logic [ADDR_W-1:0]        clr_idx_i,
    output logic [(1<<ADDR_W)-1:0]   pending_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Set is applied after clear so a same-edge reserve (new producer) wins.
    always_comb begin
        pending_d = pending_q;
        if (en_i) begin
            if (clr_i) begin
                pending_d[clr_idx_i] = 1'b0;
            end
            if (set_i) begin
                pending_d[set_idx_i] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/banco_registradores_param.sv
// General-purpose register file with post-reset clear engine, hazard scoreboard
// and optional write-to-read forwarding (enabled by defining REGFILE_BYPASS_EN).
module banco_registradores_param
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_READ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       regWrite,
    input  logic [ADDR_W-1:0]          writeReg,
    input  logic [DATA_W-1:0]          writeData,
    input  logic [N_READ*ADDR_W-1:0]   readReg,
    output logic [N_READ*DATA_W-1:0]   readData,
    input  logic                       resvValid,
    input  logic [ADDR_W-1:0]          resvReg,
    output logic [N_READ-1:0]          hazard,
    output logic [(1<<ADDR_W)-1:0]     pending,
    output logic                       ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [ADDR_W-1:0]   clr_cnt_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic                run;
    logic                wr_en;
    logic [ADDR_W-1:0]   rd_idx;

    assign run   = (state_q == ST_RUN);
    assign ready = run;
    assign wr_en = run && regWrite && (writeReg != '0);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_INIT) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage has no reset of its own; the INIT sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                regs_q[clr_cnt_q] <= '0;
            end else if (wr_en) begin
                regs_q[writeReg] <= writeData;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (run),
        .set_i     (resvValid && (resvReg != '0)),
        .set_idx_i (resvReg),
        .clr_i     (regWrite && (writeReg != '0)),
        .clr_idx_i (writeReg),
        .pending_o (pending)
    );

    always_comb begin
        readData = '0;
        hazard   = '0;
        rd_idx   = '0;
        for (int k = 0; k < N_READ; k++) begin
            rd_idx = readReg[k*ADDR_W +: ADDR_W];
            if (run && (rd_idx != '0)) begin
                readData[k*DATA_W +: DATA_W] = regs_q[rd_idx];
                hazard[k]                    = pending[rd_idx];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (writeReg == rd_idx)) begin
                    readData[k*DATA_W +: DATA_W] = writeData;
                    hazard[k]                    = 1'b0;
                end
`endif
            end
        end
    end

endmodule
